// File: rtl/cubic_interp_pkg.sv
// Shared constants, FSM encoding and fixed-point helpers for the cubic interpolation engine.
// Weight polynomials are stored as quarter-unit coefficients over the terms {t^3, t^2, t, 1}.
package cubic_interp_pkg;

  localparam logic [1:0] MODE_KEYS_A050 = 2'd0;
  localparam logic [1:0] MODE_KEYS_A075 = 2'd1;
  localparam logic [1:0] MODE_LINEAR    = 2'd2;
  localparam logic [1:0] MODE_NEAREST   = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POW2,
    ST_POW3,
    ST_WGT,
    ST_MAC0,
    ST_MAC1,
    ST_MAC2,
    ST_MAC3,
    ST_OUT
  } state_t;

  // [mode][weight k][term j], j = t^3, t^2, t, 1; value is coefficient * 4.
  // The nearest row is all zero; that mode forces a single unit weight instead.
  localparam int COEF_Q [4][4][4] = '{
    '{ '{-2,   4, -2, 0}, '{ 6, -10,  0, 4}, '{-6,  8,  2, 0}, '{ 2, -2, 0, 0} },
    '{ '{-3,   6, -3, 0}, '{ 5,  -9,  0, 4}, '{-5,  6,  3, 0}, '{ 3, -3, 0, 0} },
    '{ '{ 0,   0,  0, 0}, '{ 0,   0, -4, 4}, '{ 0,  0,  4, 0}, '{ 0,  0, 0, 0} },
    '{ '{ 0,   0,  0, 0}, '{ 0,   0,  0, 0}, '{ 0,  0,  0, 0}, '{ 0,  0, 0, 0} }
  };

  // Round half toward +inf, then arithmetic shift right by sh (sh >= 1).
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int sh);
    logic signed [63:0] half;
    half = 64'sd1 <<< (sh - 1);
    return (x + half) >>> sh;
  endfunction

  // Multiply by a small constant using shifts and adds; folds away when c is constant.
  function automatic logic signed [63:0] cmul(input int c, input logic signed [63:0] x);
    logic signed [63:0] acc;
    int mag;
    acc = '0;
    mag = (c < 0) ? -c : c;
    for (int b = 0; b < 8; b++) begin
      if (mag[b]) acc = acc + (x <<< b);
    end
    return (c < 0) ? -acc : acc;
  endfunction

endpackage

// File: rtl/cubic_interp_engine_if.sv
// Request/response bundle between the tap fetch logic and the cubic interpolation engine.
interface cubic_interp_engine_if #(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8,
  parameter int CH     = 1
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [FRAC_W-1:0]       in_frac;
  logic [1:0]              in_mode;
  logic [CH*4*PIX_W-1:0]   in_pix;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH*PIX_W-1:0]     out_pix;
  logic                    busy;

  modport master (
    output in_valid, in_frac, in_mode, in_pix, out_ready,
    input  in_ready, out_valid, out_pix, busy
  );

  modport slave (
    input  in_valid, in_frac, in_mode, in_pix, out_ready,
    output in_ready, out_valid, out_pix, busy
  );

endinterface

// File: rtl/cubic_weight_gen.sv
// Combinational tap-weight generator: (t, t^2, t^3, mode) -> four signed Q.FRAC_W weights.
// Every mode's polynomial is evaluated with constant shift-adds, then the mode selects one set.
module cubic_weight_gen
  import cubic_interp_pkg::*;
#(
  parameter int FRAC_W = 8
) (
  input  logic [FRAC_W-1:0]        t,
  input  logic [FRAC_W-1:0]        t2,
  input  logic [FRAC_W-1:0]        t3,
  input  logic [1:0]               mode,
  output logic signed [FRAC_W+2:0] w [4]
);

  localparam int WW = FRAC_W + 3;
  localparam logic signed [WW-1:0] W_ONE = WW'(1 << FRAC_W);

  logic signed [63:0]    pw [4];
  logic signed [WW-1:0]  w_mode [4][4];

  assign pw[0] = 64'(t3);
  assign pw[1] = 64'(t2);
  assign pw[2] = 64'(t);
  assign pw[3] = 64'sd1 <<< FRAC_W;

  // Sum is in Q.(FRAC_W+2); the final round drops the two quarter-unit bits.
  genvar gi, gk;
  for (gi = 0; gi < 4; gi++) begin : g_mode
    for (gk = 0; gk < 4; gk++) begin : g_wgt
      logic signed [63:0] x_q;
      assign x_q = cmul(COEF_Q[gi][gk][0], pw[0]) + cmul(COEF_Q[gi][gk][1], pw[1])
                 + cmul(COEF_Q[gi][gk][2], pw[2]) + cmul(COEF_Q[gi][gk][3], pw[3]);
      assign w_mode[gi][gk] = WW'(round_shift(x_q, 2));
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) w[k] = w_mode[mode][k];
    if (mode == MODE_NEAREST) begin
      if (t[FRAC_W-1]) w[2] = W_ONE;
      else             w[1] = W_ONE;
    end
  end

endmodule

// File: rtl/cubic_interp_engine.sv
// Multi-cycle N-channel cubic interpolator: powers of t, weights, four MAC steps, round/clamp.
// One request in flight at a time; result is held until the consumer takes it.
module cubic_interp_engine
  import cubic_interp_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8,
  parameter int CH     = 1
) (
  input logic                 clk,
  input logic                 rst,
  cubic_interp_engine_if.slave bus
);

  localparam int WW  = FRAC_W + 3;
  localparam int AW  = PIX_W + FRAC_W + 5;
  localparam int TW  = CH * 4 * PIX_W;
  localparam int PW2 = 2 * FRAC_W;
  localparam logic signed [AW-1:0] PIX_MAX = AW'({PIX_W{1'b1}});

  state_t                 state_reg, state_next;
  logic [FRAC_W-1:0]      t_reg, t2_reg, t3_reg;
  logic [1:0]             mode_reg;
  logic [TW-1:0]          tap_reg;
  logic signed [WW-1:0]   w_reg [4];
  logic signed [WW-1:0]   w_gen [4];
  logic signed [AW-1:0]   acc_reg [CH];
  logic signed [AW-1:0]   acc_next [CH];
  logic [PIX_W-1:0]       pix_next [CH];
  logic [CH*PIX_W-1:0]    out_pix_reg;
  logic [1:0]             mac_idx;
  logic [PW2-1:0]         sq_prod;
  logic [FRAC_W-1:0]      pow_next;
  logic signed [WW-1:0]   w_sel;

  // One multiplier serves both power stages: t*t in POW2, t2*t in POW3.
  assign sq_prod  = PW2'((state_reg == ST_POW2) ? t_reg : t2_reg) * PW2'(t_reg);
  assign pow_next = FRAC_W'(round_shift(64'(sq_prod), FRAC_W));

  cubic_weight_gen #(.FRAC_W(FRAC_W)) u_weight_gen (
    .t    (t_reg),
    .t2   (t2_reg),
    .t3   (t3_reg),
    .mode (mode_reg),
    .w    (w_gen)
  );

  assign w_sel = w_reg[mac_idx];

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_mac
    logic [PIX_W-1:0]     tap;
    logic signed [AW-1:0] prod, sum, rnd;
    assign tap  = tap_reg[(gi*4 + int'(mac_idx))*PIX_W +: PIX_W];
    assign prod = AW'(w_sel) * AW'($signed({1'b0, tap}));
    assign sum  = acc_reg[gi] + prod;
    assign rnd  = AW'(round_shift(64'(sum), FRAC_W));
    assign acc_next[gi] = sum;
    assign pix_next[gi] = (rnd < 0) ? '0 : (rnd > PIX_MAX) ? '1 : rnd[PIX_W-1:0];
  end

  always_comb begin
    state_next = state_reg;
    mac_idx    = 2'd0;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) state_next = ST_POW2;
      ST_POW2: state_next = ST_POW3;
      ST_POW3: state_next = ST_WGT;
      ST_WGT:  state_next = ST_MAC0;
      ST_MAC0: begin mac_idx = 2'd0; state_next = ST_MAC1; end
      ST_MAC1: begin mac_idx = 2'd1; state_next = ST_MAC2; end
      ST_MAC2: begin mac_idx = 2'd2; state_next = ST_MAC3; end
      ST_MAC3: begin mac_idx = 2'd3; state_next = ST_OUT;  end
      ST_OUT:  if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      t_reg       <= '0;
      t2_reg      <= '0;
      t3_reg      <= '0;
      mode_reg    <= '0;
      tap_reg     <= '0;
      out_pix_reg <= '0;
      for (int k = 0; k < 4; k++) w_reg[k] <= '0;
      for (int c = 0; c < CH; c++) acc_reg[c] <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            t_reg    <= bus.in_frac;
            mode_reg <= bus.in_mode;
            tap_reg  <= bus.in_pix;
          end
        end
        ST_POW2: t2_reg <= pow_next;
        ST_POW3: t3_reg <= pow_next;
        ST_WGT: begin
          for (int k = 0; k < 4; k++) w_reg[k] <= w_gen[k];
          for (int c = 0; c < CH; c++) acc_reg[c] <= '0;
        end
        ST_MAC0, ST_MAC1, ST_MAC2: begin
          for (int c = 0; c < CH; c++) acc_reg[c] <= acc_next[c];
        end
        ST_MAC3: begin
          for (int c = 0; c < CH; c++) out_pix_reg[c*PIX_W +: PIX_W] <= pix_next[c];
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_OUT);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.out_pix   = out_pix_reg;

endmodule

// File: tb/tb_cubic_interp_engine.sv
// Directed vector table on a default engine plus backpressure/reset sequences and
// a 3-channel, 10-bit engine checked against a formula-level model.
module tb_cubic_interp_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cubic_interp_engine_if #(.PIX_W(8),  .FRAC_W(8), .CH(1)) bus ();
  cubic_interp_engine_if #(.PIX_W(10), .FRAC_W(8), .CH(3)) bus3 ();

  cubic_interp_engine #(.PIX_W(8),  .FRAC_W(8), .CH(1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  cubic_interp_engine #(.PIX_W(10), .FRAC_W(8), .CH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  t;
    logic [31:0] pix;   // {P2, P1, P0, P-1}
    int          exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input int m, input int t, input int pm1, input int p0,
                              input int p1, input int p2, input int e);
    vec_t v;
    v.mode = 2'(m);
    v.t    = 8'(t);
    v.pix  = {8'(p2), 8'(p1), 8'(p0), 8'(pm1)};
    v.exp  = e;
    return v;
  endfunction

  // Independent model written straight from the Keys/linear/nearest formulas, FRAC_W = 8.
  function automatic int model(input int m, input int t, input int p [4]);
    int t2, t3, aq, acc, r;
    int x [4];
    int w [4];
    t2 = (t * t + 128) >>> 8;
    t3 = (t2 * t + 128) >>> 8;
    if (m < 2) begin
      aq   = (m == 0) ? -2 : -3;
      x[0] = aq * t3 - 2 * aq * t2 + aq * t;
      x[1] = (aq + 8) * t3 - (aq + 12) * t2 + 1024;
      x[2] = -(aq + 8) * t3 + (2 * aq + 12) * t2 - aq * t;
      x[3] = -aq * t3 + aq * t2;
      for (int k = 0; k < 4; k++) w[k] = (x[k] + 2) >>> 2;
    end else if (m == 2) begin
      w = '{0, 256 - t, t, 0};
    end else begin
      w = (t < 128) ? '{0, 256, 0, 0} : '{0, 0, 256, 0};
    end
    acc = 0;
    for (int k = 0; k < 4; k++) acc += w[k] * p[k];
    r = (acc + 128) >>> 8;
    if (r < 0) r = 0;
    if (r > 1023) r = 1023;
    return r;
  endfunction

  // Starts and ends on a negedge with the engine idle; out_ready must be high.
  task automatic run_vec(input vec_t v, input string tag);
    int edges;
    int low;
    bus.in_mode  = v.mode;
    bus.in_frac  = v.t;
    bus.in_pix   = v.pix;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 0;
    low   = 0;
    while (!bus.out_valid && edges < 20) begin
      if (!bus.in_ready) low++;
      @(negedge clk);
      edges++;
    end
    if (!bus.in_ready) low++;
    check({tag, "_latency"}, 64'(edges), 64'd7);
    check({tag, "_pix"}, 64'(bus.out_pix), 64'(v.exp));
    @(negedge clk);
    check({tag, "_ready_low_cycles"}, 64'(low), 64'd8);
    check({tag, "_valid_dropped"}, 64'(bus.out_valid), 64'd0);
    $display("vec %s mode=%0d t=%0d pix=%h -> out=%0d exp=%0d", tag, v.mode, v.t, v.pix, bus.out_pix, v.exp);
  endtask

  task automatic run3(input int m, input int t, input int taps [12], input int idx);
    logic [119:0] packed_taps;
    int edges;
    int p [4];
    int e;
    for (int i = 0; i < 12; i++) packed_taps[i*10 +: 10] = 10'(taps[i]);
    bus3.in_mode  = 2'(m);
    bus3.in_frac  = 8'(t);
    bus3.in_pix   = packed_taps;
    bus3.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    edges = 0;
    while (!bus3.out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check($sformatf("ch3_%0d_latency", idx), 64'(edges), 64'd7);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) p[k] = taps[c*4 + k];
      e = model(m, t, p);
      check($sformatf("ch3_%0d_c%0d_mode%0d_t%0d", idx, c, m, t), 64'(bus3.out_pix[c*10 +: 10]), 64'(e));
    end
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int taps [12];
    int m, t;

    vecs[0]  = mk(0,   0,  10,  20,  30,  40,  20);
    vecs[1]  = mk(0, 128,   0, 100, 200, 255, 153);
    vecs[2]  = mk(0, 128,   0, 255, 255,   0, 255);
    vecs[3]  = mk(0, 128, 255,   0,   0, 255,   0);
    vecs[4]  = mk(2,  64,   7, 100, 200,   9, 125);
    vecs[5]  = mk(3, 128,   1,   2,   3,   4,   3);
    vecs[6]  = mk(3, 127,   1,   2,   3,   4,   2);
    vecs[7]  = mk(1, 128,   0, 100, 200, 255, 154);
    vecs[8]  = mk(0,  64,  10,  50,  90, 130,  60);
    vecs[9]  = mk(2, 255,   0,   0, 255,   0, 254);
    vecs[10] = mk(3,   0,   9,   8,   7,   6,   8);
    vecs[11] = mk(1,   0,  10,  20,  30,  40,  20);

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_frac = '0;  bus.in_mode = '0;  bus.in_pix = '0;  bus.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.in_frac = '0; bus3.in_mode = '0; bus3.in_pix = '0; bus3.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_pix",   64'(bus.out_pix),   64'd0);
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_busy",      64'(bus.busy),      64'd0);
    check("reset3_out_pix",  64'(bus3.out_pix),  64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Backpressure: hold the result while a second request is presented and ignored.
    bus.out_ready = 1'b0;
    bus.in_mode = 2'd0; bus.in_frac = 8'd128; bus.in_pix = vecs[1].pix; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int e = 0; e < 20 && !bus.out_valid; e++) @(negedge clk);
    bus.in_mode = 2'd3; bus.in_frac = 8'd0; bus.in_pix = vecs[5].pix; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("bp_hold_pix_%0d", i),   64'(bus.out_pix),   64'd153);
      check($sformatf("bp_in_ready_%0d", i),   64'(bus.in_ready),  64'd0);
      $display("bp cycle %0d out_valid=%0d out_pix=%0d in_ready=%0d", i, bus.out_valid, bus.out_pix, bus.in_ready);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_busy",  64'(bus.busy),      64'd0);
    @(negedge clk);
    check("bp_not_queued",    64'(bus.busy),      64'd0);
    run_vec(vecs[7], "bp_next");

    // Reset while the engine is in MAC1 drops the job and clears the output.
    run_vec(vecs[1], "pre_rst");
    bus.in_mode = 2'd0; bus.in_frac = 8'd128; bus.in_pix = vecs[1].pix; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mac1_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mac1_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mac1_out_pix",   64'(bus.out_pix),   64'd0);
    check("rst_mac1_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_mac1_busy",      64'(bus.busy),      64'd0);
    $display("rst in MAC1 -> out_valid=%0d out_pix=%0d in_ready=%0d", bus.out_valid, bus.out_pix, bus.in_ready);
    run_vec(vecs[0], "post_rst");

    // Three channels, 10-bit pixels, random t/taps/modes against the model.
    for (int i = 0; i < 1000; i++) begin
      m = $urandom_range(0, 3);
      t = (i < 4) ? ((i == 0) ? 0 : (i == 1) ? 127 : (i == 2) ? 128 : 255) : $urandom_range(0, 255);
      for (int k = 0; k < 12; k++) taps[k] = $urandom_range(0, 1023);
      run3(m, t, taps, i);
      if (i % 100 == 0) $display("ch3 run %0d mode=%0d t=%0d out_pix=%h", i, m, t, bus3.out_pix);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
